hamming_mem_engine: RTL and testbench
=====================================

Name: hamming_mem_engine

Overview:
- Hardware SEC-DED Hamming engine that runs directly against the byte-wide data memory.
- Encode mode: reads NUM_MSG 11-bit messages from a source region and writes 16-bit codewords with parity embedded to a destination region.
- Decode mode: reads codewords, corrects any single error, flags double errors and writes the 11-bit data back with status flags.
- Replaces the software parity programs. Started by a start/done handshake from the top level.

Parameters:
ADDR_W, 8, data-memory address width in bits
NUM_MSG, 15, messages per run (1..127)
SRC_BASE, 0, byte address of the first source word (low byte)
DST_BASE, 30, byte address of the first destination word (low byte)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle run request
mode  input  1  0 = encode, 1 = decode; sampled with start
busy  output  1  high while a run is in progress
done  output  1  high from end of run until next accepted start
mem_addr  output  ADDR_W  data-memory byte address
mem_we  output  1  data-memory write enable
mem_wdata  output  8  data-memory write data
mem_rdata  input  8  data-memory read data; valid one cycle after address (synchronous read)
err_single  output  8  count of corrected single errors in the last decode run
err_double  output  8  count of detected double errors in the last decode run

Behaviour:
- Word i sits at base+2i (low byte) and base+2i+1 (high byte). Addresses wrap modulo 2^ADDR_W.
- Encode input format: high byte = {5'b0, d[11:9]}, low byte = d[8:1]. Upper 5 input bits are ignored.
- Codeword bit k (k = 1..15) is Hamming position k, bit 0 is p0:
  - cw = {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
  - p1/p2/p4/p8 give even parity over the positions with that index bit set.
  - p0 gives even parity over all 16 bits.
- Decode:
  - Syndrome s = XOR of the indices of set bits 1..15. P = XOR of all 16 bits.
  - s=0, P=0: flag 00.
  - P=1: flip position s (s=0 means p0), flag 01, err_single++.
  - s!=0, P=0: flag 10, data left uncorrected, err_double++.
  - Output high byte = {flag[1:0], 3'b0, d[11:9]}, low byte = d[8:1].
- FSM states: IDLE, RD_LO, RD_HI, CAPT, WR_LO, WR_HI, FIN.
  - IDLE: start=1 latches mode, clears counters and done, sets busy, goes to RD_LO.
  - RD_LO: mem_addr = src low byte.
  - RD_HI: capture low byte; mem_addr = src high byte.
  - CAPT: capture high byte; compute the result combinationally.
  - WR_LO: mem_we=1, write dst low byte.
  - WR_HI: mem_we=1, write dst high byte; if last message go to FIN, else increment the index and go to RD_LO.
  - FIN: busy=0, done=1, return to IDLE.
- Timing: exactly 5 cycles per message. done rises on the edge 5*NUM_MSG+1 cycles after the start-sampling edge.
- Each word is fully read before it is written, so SRC_BASE == DST_BASE (in-place) is legal.
- mem_we is 0 in every state except WR_LO and WR_HI. mem_addr and mem_wdata are don't-care when not reading or writing.
- start while busy is ignored. start in the same cycle as FIN is ignored.
- Reset values (asynchronous, immediate, including mid-run): state IDLE, busy 0, done 0, mem_we 0, mem_addr 0, mem_wdata 0, both counters 0, index 0.
- Counters are 8 bits and cannot overflow (NUM_MSG <= 127). They are cleared only by an accepted start or by reset.

Test Plan:
- Encode, word 0 = {8'h07, 8'hFF} (d = 11'h7FF), word 1 = {8'h00, 8'h01}: dst bytes = FF, FF, then 0F, 00 (cw 16'h000F). done high, counters 0.
- Decode 16'h020F (bit 9 flipped): out high 8'h40, low 8'h01, err_single = 1. Decode 16'h000E (p0 flipped): out 8'h40 / 8'h01.
- Decode 16'h060F (bits 9 and 10 flipped): out high 8'h80, low 8'h31, err_double = 1, err_single unchanged.
- Round trip, NUM_MSG = 15, 15 random messages: encode, then in-place decode with each word's single flip at bit i → all flags 01, data matches, err_single = 15. done exactly 76 cycles after start.
- Drive reset low during message 7 of a run: mem_we, busy and done go to 0 asynchronously. No further writes. A subsequent start runs cleanly from message 0.
- start pulsed while busy, plus a run with NUM_MSG = 1: extra start is ignored, done timing is unchanged, the single-message run completes in 6 cycles.

Source files
------------

// File: rtl/hamming_mem_engine.sv
// hamming_mem_engine: SEC-DED Hamming(16,11) encode/decode engine working in place on byte-wide data memory.
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   start_i, mode_i           single-cycle run request; mode 0 = encode, 1 = decode (sampled with start)
//   busy_o, done_o            run in progress / run finished (held until next accepted start)
//   mem_addr_o, mem_we_o,
//   mem_wdata_o, mem_rdata_i  data-memory port, synchronous read (data one cycle after address)
//   err_single_o, err_double_o corrected / detected error counts of the last decode run
module hamming_mem_engine #(
  parameter int ADDR_W   = 8,
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [7:0]        err_single_o,
  output logic [7:0]        err_double_o
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAPT, WR_LO, WR_HI, FIN} state_e;
  state_e            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic              mode_q, mode_d, done_q, done_d;
  logic [7:0]        lo_q, lo_d, hi_q, hi_d, es_q, es_d, ed_q, ed_d;
  logic              last, accept;
  logic [ADDR_W-1:0] src_a, dst_a;
  logic [10:0]       d_in, dat;
  logic [15:0]       c, ep, enc, cw, cw_fix, res;
  logic [3:0]        syn;
  logic              par;
  logic [1:0]        flag;
  logic              unused_bits;

  assign last   = idx_q == 7'(NUM_MSG - 1);
  assign accept = state_q == IDLE && start_i;
  assign src_a  = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
  assign dst_a  = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});

  // Encode: data bits go to the non-power-of-two positions, then p1/p2/p4/p8, then p0 over the rest.
  assign d_in = {hi_q[2:0], lo_q};
  assign c    = {d_in[10:4], 1'b0, d_in[3:1], 1'b0, d_in[0], 3'b0};
  assign ep   = c | {7'b0, ^(c & 16'hFF00), 3'b0, ^(c & 16'hF0F0), 1'b0,
                     ^(c & 16'hCCCC), ^(c & 16'hAAAA), 1'b0};
  assign enc  = {ep[15:1], ^ep};

  // Decode: odd overall parity means a single error at position syn (0 = p0 itself).
  assign cw     = {hi_q, lo_q};
  assign syn    = {^(cw & 16'hFF00), ^(cw & 16'hF0F0), ^(cw & 16'hCCCC), ^(cw & 16'hAAAA)};
  assign par    = ^cw;
  assign flag   = par ? 2'b01 : (syn != 4'd0 ? 2'b10 : 2'b00);
  assign cw_fix = par ? cw ^ (16'd1 << syn) : cw;
  assign dat    = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
  assign unused_bits = ^{cw_fix[8], cw_fix[4], cw_fix[2:0]};

  assign res = mode_q ? {flag, 3'b0, dat} : enc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      es_q    <= '0;
      ed_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      es_q    <= es_d;
      ed_q    <= ed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? RD_LO : IDLE;
      RD_LO:   state_d = RD_HI;
      RD_HI:   state_d = CAPT;
      CAPT:    state_d = WR_LO;
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = last ? FIN : RD_LO;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d = accept ? mode_i : mode_q;
    idx_d  = accept ? 7'd0 : (state_q == WR_HI && !last) ? idx_q + 7'd1 : idx_q;
    done_d = accept ? 1'b0 : (state_q == FIN) ? 1'b1 : done_q;
    lo_d   = state_q == RD_HI ? mem_rdata_i : lo_q;
    hi_d   = state_q == CAPT ? mem_rdata_i : hi_q;
    es_d   = accept ? 8'd0 : (state_q == WR_HI && mode_q && flag == 2'b01) ? es_q + 8'd1 : es_q;
    ed_d   = accept ? 8'd0 : (state_q == WR_HI && mode_q && flag == 2'b10) ? ed_q + 8'd1 : ed_q;
  end

  always_comb begin
    busy_o      = state_q != IDLE && state_q != FIN;
    done_o      = done_q;
    mem_we_o    = state_q == WR_LO || state_q == WR_HI;
    mem_addr_o  = state_q == RD_LO ? src_a :
                  state_q == RD_HI ? src_a + ADDR_W'(1) :
                  state_q == WR_LO ? dst_a :
                  state_q == WR_HI ? dst_a + ADDR_W'(1) : '0;
    mem_wdata_o = state_q == WR_LO ? res[7:0] : state_q == WR_HI ? res[15:8] : 8'd0;
    err_single_o = es_q;
    err_double_o = ed_q;
  end
endmodule

// File: tb/tb_hamming_mem_engine.sv
// tb_hamming_mem_engine: directed self-checking bench for hamming_mem_engine with a shared byte memory.
module tb_hamming_mem_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] st = 3'b0;
  logic [7:0] addr [3];
  logic [7:0] wd [3];
  logic [7:0] es [3];
  logic [7:0] ed [3];
  logic [2:0] we, busy, done;
  logic [7:0] rdata;
  logic [7:0] mem [256];
  int         sel = 0;
  logic       ld_we = 1'b0;
  logic [7:0] ld_a = 8'd0, ld_d = 8'd0;
  int         wr_cnt = 0;
  int         nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  hamming_mem_engine #(.ADDR_W(8), .NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .mode_i(mode), .busy_o(busy[0]), .done_o(done[0]),
    .mem_addr_o(addr[0]), .mem_we_o(we[0]), .mem_wdata_o(wd[0]), .mem_rdata_i(rdata),
    .err_single_o(es[0]), .err_double_o(ed[0]));
  hamming_mem_engine #(.ADDR_W(8), .NUM_MSG(15), .SRC_BASE(240), .DST_BASE(240)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .mode_i(mode), .busy_o(busy[1]), .done_o(done[1]),
    .mem_addr_o(addr[1]), .mem_we_o(we[1]), .mem_wdata_o(wd[1]), .mem_rdata_i(rdata),
    .err_single_o(es[1]), .err_double_o(ed[1]));
  hamming_mem_engine #(.ADDR_W(8), .NUM_MSG(1), .SRC_BASE(50), .DST_BASE(60)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]), .mode_i(mode), .busy_o(busy[2]), .done_o(done[2]),
    .mem_addr_o(addr[2]), .mem_we_o(we[2]), .mem_wdata_o(wd[2]), .mem_rdata_i(rdata),
    .err_single_o(es[2]), .err_double_o(ed[2]));

  always @(posedge clk) begin
    if (ld_we) mem[ld_a] <= ld_d;
    else if (we[sel]) mem[addr[sel]] <= wd[sel];
    rdata <= mem[addr[sel]];
    if (|we) wr_cnt <= wr_cnt + 1;
  end

  function automatic logic [15:0] tenc(input logic [10:0] d);
    logic [15:0] cw;
    logic        p;
    int          j;
    cw = '0;
    j = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin
        cw[k] = d[j];
        j++;
      end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if (k[b]) p ^= cw[k];
      cw[1 << b] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] rdw(input logic [7:0] a);
    return {mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lda(input logic [7:0] a, input logic [7:0] d);
    ld_a = a;
    ld_d = d;
    ld_we = 1'b1;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic ldw(input logic [7:0] a, input logic [15:0] w);
    lda(a, w[7:0]);
    lda(a + 8'd1, w[15:8]);
  endtask

  task automatic run(input int u, input logic md, output int cyc);
    mode = md;
    st[u] = 1'b1;
    @(posedge clk);
    #1 st[u] = 1'b0;
    cyc = 0;
    while (!done[u] && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [10:0] d [15];
    logic [15:0] cw [15];
    logic [4:0]  g;
    int          cyc, wc;

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr[0]), 0);
    chk("rst_wdata", 32'(wd[0]), 0);
    chk("rst_es", 32'(es[0]), 0);
    chk("rst_ed", 32'(ed[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sel = 0;
    for (int i = 0; i < 15; i++) begin
      d[i] = i == 0 ? 11'h7FF : i == 1 ? 11'h001 : 11'($urandom);
      g = i < 2 ? 5'd0 : 5'($urandom);
      cw[i] = tenc(d[i]);
      ldw(8'(2 * i), {g, d[i]});
    end
    run(0, 1'b0, cyc);
    chk("enc_cycles", cyc, 76);
    chk("enc_done", 32'(done[0]), 1);
    chk("enc_busy", 32'(busy[0]), 0);
    chk("enc_b30", 32'(mem[30]), 32'hFF);
    chk("enc_b31", 32'(mem[31]), 32'hFF);
    chk("enc_b32", 32'(mem[32]), 32'h0F);
    chk("enc_b33", 32'(mem[33]), 32'h00);
    chk("enc_es", 32'(es[0]), 0);
    chk("enc_ed", 32'(ed[0]), 0);
    for (int i = 2; i < 15; i++) chk($sformatf("enc_cw%0d", i), 32'(rdw(8'(30 + 2 * i))), 32'(cw[i]));

    ldw(8'd0, 16'h020F);
    ldw(8'd2, 16'h000E);
    ldw(8'd4, 16'h060F);
    for (int i = 3; i < 15; i++) ldw(8'(2 * i), cw[i]);
    run(0, 1'b1, cyc);
    chk("dec_cycles", cyc, 76);
    chk("dec_bit9", 32'(rdw(8'd30)), 32'h4001);
    chk("dec_p0", 32'(rdw(8'd32)), 32'h4001);
    chk("dec_double", 32'(rdw(8'd34)), 32'h8031);
    for (int i = 3; i < 15; i++) chk($sformatf("dec_clean%0d", i), 32'(rdw(8'(30 + 2 * i))), 32'({5'b0, d[i]}));
    chk("dec_es", 32'(es[0]), 2);
    chk("dec_ed", 32'(ed[0]), 1);

    sel = 1;
    for (int i = 0; i < 15; i++) ldw(8'(240 + 2 * i), cw[i] ^ (16'd1 << i));
    run(1, 1'b1, cyc);
    chk("rt_cycles", cyc, 76);
    for (int i = 0; i < 15; i++) chk($sformatf("rt_word%0d", i), 32'(rdw(8'(240 + 2 * i))), 32'({5'b01000, d[i]}));
    chk("rt_es", 32'(es[1]), 15);
    chk("rt_ed", 32'(ed[1]), 0);

    for (int i = 0; i < 15; i++) ldw(8'(240 + 2 * i), cw[i] ^ (16'd1 << i));
    mode = 1'b1;
    st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (38) @(posedge clk);
    #2;
    chk("mid_we_pre", 32'(we[1]), 1);
    chk("mid_busy_pre", 32'(busy[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(we), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_es", 32'(es[1]), 0);
    chk("arst_addr", 32'(addr[1]), 0);
    wc = wr_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_nowrites", wr_cnt, wc);
    chk("arst_idle", 32'(busy[1]), 0);
    for (int i = 0; i < 15; i++) ldw(8'(240 + 2 * i), cw[i] ^ (16'd1 << i));
    run(1, 1'b1, cyc);
    chk("rerun_cycles", cyc, 76);
    for (int i = 0; i < 15; i++) chk($sformatf("rerun_word%0d", i), 32'(rdw(8'(240 + 2 * i))), 32'({5'b01000, d[i]}));
    chk("rerun_es", 32'(es[1]), 15);

    sel = 2;
    ldw(8'd50, 16'h07FF);
    mode = 1'b0;
    st[2] = 1'b1;
    @(posedge clk);
    #1 st[2] = 1'b0;
    cyc = 0;
    while (!done[2] && cyc < 50) begin
      if (cyc == 2 || cyc == 5) st[2] = 1'b1;
      @(posedge clk);
      #1 st[2] = 1'b0;
      cyc++;
    end
    chk("one_cycles", cyc, 6);
    chk("one_cw", 32'(rdw(8'd60)), 32'hFFFF);
    @(posedge clk);
    #1;
    chk("fin_start_busy", 32'(busy[2]), 0);
    chk("fin_start_done", 32'(done[2]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
